// File: rtl/tape_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tape_pkg (package)
//  Description : Shared definitions for the tape memory and the core-side
//                select stage: cell width, address width, fixed load
//                latency and the CLEAR/RUN state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package tape_pkg;

    // Width of one tape cell; cell contents are opaque data here.
    localparam int CELL_W     = 16;

    // Width of the request address fields on the core side.
    localparam int ADDR_W     = 16;

    // Cycles from load acceptance to the ld_valid strobe.
    localparam int LD_LATENCY = 2;

    // Memory controller state: zeroing the array, or serving requests.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } tape_state_t;

endpackage : tape_pkg
`default_nettype wire

// File: rtl/tape_mem_if.sv
`default_nettype none
// ============================================================================
//  Module      : tape_mem_if (interface)
//  Description : Core <-> tape memory request/response bundle.
//                master : the core (drives load/store requests)
//                slave  : tape_mem (returns load data, ready, err)
//  Signals     : ld_en/ld_addr    load request
//                st_en/st_addr/st_data store request
//                ld_data/ld_valid load response (fixed latency)
//                ready            requests are accepted
//                err              sticky out-of-range flag
//  Revision    : 1.0 - initial release
// ============================================================================
interface tape_mem_if;
    import tape_pkg::*;

    logic              ld_en;
    logic [ADDR_W-1:0] ld_addr;
    logic              st_en;
    logic [ADDR_W-1:0] st_addr;
    logic [CELL_W-1:0] st_data;
    logic [CELL_W-1:0] ld_data;
    logic              ld_valid;
    logic              ready;
    logic              err;

    modport master (
        output ld_en, ld_addr, st_en, st_addr, st_data,
        input  ld_data, ld_valid, ready, err
    );

    modport slave (
        input  ld_en, ld_addr, st_en, st_addr, st_data,
        output ld_data, ld_valid, ready, err
    );

endinterface : tape_mem_if
`default_nettype wire

// File: rtl/tape_ram.sv
`default_nettype none
// ============================================================================
//  Module      : tape_ram
//  Description : Synchronous cell array, one write port and one read port.
//                The write port covers an aligned group of LANES cells with
//                a per-cell enable mask, so a whole clear group or a single
//                cell can be written in one cycle. Reads are registered and
//                return the value held before a same-edge write.
//  Ports       : clk       clock
//                i_we      write enable
//                i_wbase   cell index of lane 0 of the write group
//                i_wmask   per-lane write enable
//                i_wdata   data written to every enabled lane
//                i_raddr   read cell index
//                o_rdata   registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_ram
    import tape_pkg::*;
#(
    parameter int DEPTH = 1024,
    parameter int LANES = 1
) (
    input  wire logic                     clk,
    input  wire logic                     i_we,
    input  wire logic [$clog2(DEPTH)-1:0] i_wbase,
    input  wire logic [LANES-1:0]         i_wmask,
    input  wire logic [CELL_W-1:0]        i_wdata,
    input  wire logic [$clog2(DEPTH)-1:0] i_raddr,
    output      logic [CELL_W-1:0]        o_rdata
);

    localparam int c_aw = $clog2(DEPTH);

    logic [CELL_W-1:0] r_mem [DEPTH];
    logic [CELL_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int l = 0; l < LANES; l++) begin
                if (i_wmask[l]) begin
                    r_mem[i_wbase + c_aw'(l)] <= i_wdata;
                end
            end
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule : tape_ram
`default_nettype wire

// File: rtl/tape_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tape_mem
//  Description : Tape memory for the core. After reset the array is zeroed
//                CLR_PER_CYC cells per cycle (CLEAR), then loads and stores
//                are served (RUN). Loads return after a fixed two-cycle
//                latency, fully pipelined, with write-first forwarding from
//                a same-cycle store to the same cell.
//  Params      : DEPTH        number of 16-bit cells (power of two)
//                CLR_PER_CYC  cells zeroed per clear cycle (power of two)
//  Ports       : clk          clock, rising edge
//                rst          asynchronous active-high reset
//                bus          tape_mem_if.slave request/response bundle
//  Option      : TAPE_MEM_RANGE_CHECK_EN - addresses >= DEPTH are flagged
//                (sticky err), stores dropped and loads return zero.
//                Without it addresses wrap modulo DEPTH and err is 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module tape_mem
    import tape_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int CLR_PER_CYC = 1
) (
    input  wire logic   clk,
    input  wire logic   rst,
    tape_mem_if.slave   bus
);

    localparam int              c_aw        = $clog2(DEPTH);
    localparam logic [c_aw-1:0] c_lane_mask = c_aw'(CLR_PER_CYC - 1);
    localparam logic [c_aw-1:0] c_grp_step  = c_aw'(CLR_PER_CYC);
    localparam logic [c_aw-1:0] c_last_grp  = c_aw'(DEPTH - CLR_PER_CYC);

    // ------------------------------------------------------------------
    // Control state
    // ------------------------------------------------------------------
    tape_state_t       r_state;
    logic              r_ready;
    logic [c_aw-1:0]   r_clr_cnt;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [c_aw-1:0]        w_ld_cell;
    logic [c_aw-1:0]        w_st_cell;
    logic                   w_ld_oor;
    logic                   w_st_oor;
    logic                   w_ld_acc;
    logic                   w_st_acc;
    logic                   w_st_wr;
    logic                   w_unused_addr_hi;

    assign w_ld_cell = bus.ld_addr[c_aw-1:0];
    assign w_st_cell = bus.st_addr[c_aw-1:0];

    // Upper address bits only matter to the optional range check.
    assign w_unused_addr_hi = ^{bus.ld_addr, bus.st_addr};

    // Requests are only honoured once the array has been cleared.
    assign w_ld_acc = r_ready & bus.ld_en;
    assign w_st_acc = r_ready & bus.st_en;
    assign w_st_wr  = w_st_acc & ~w_st_oor;

`ifdef TAPE_MEM_RANGE_CHECK_EN
    logic r_err;

    assign w_ld_oor = ({16'h0000, bus.ld_addr} >= 32'(DEPTH));
    assign w_st_oor = ({16'h0000, bus.st_addr} >= 32'(DEPTH));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if ((w_ld_acc & w_ld_oor) | (w_st_acc & w_st_oor)) begin
            r_err <= 1'b1;
        end
    end

    assign bus.err = r_err;
`else
    assign w_ld_oor = 1'b0;
    assign w_st_oor = 1'b0;
    assign bus.err  = 1'b0;
`endif

    // ------------------------------------------------------------------
    // CLEAR / RUN state machine. ready is registered and rises together
    // with the state change, i.e. the cycle after the last group write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= CLEAR;
            r_ready   <= 1'b0;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                CLEAR: begin
                    r_clr_cnt <= r_clr_cnt + c_grp_step;
                    if (r_clr_cnt == c_last_grp) begin
                        r_state <= RUN;
                        r_ready <= 1'b1;
                    end
                end
                RUN: begin
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= CLEAR;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RAM write port: clear groups while clearing, stores while running.
    // ------------------------------------------------------------------
    logic                   w_ram_we;
    logic [c_aw-1:0]        w_ram_wbase;
    logic [CLR_PER_CYC-1:0] w_ram_wmask;
    logic [CELL_W-1:0]      w_ram_wdata;
    logic [CELL_W-1:0]      w_ram_q;

    always_comb begin
        w_ram_we    = 1'b0;
        w_ram_wbase = '0;
        w_ram_wmask = '0;
        w_ram_wdata = '0;
        if (r_state == CLEAR) begin
            w_ram_we    = 1'b1;
            w_ram_wbase = r_clr_cnt;
            w_ram_wmask = '1;
        end else begin
            w_ram_we    = w_st_wr;
            w_ram_wbase = w_st_cell & ~c_lane_mask;
            w_ram_wmask = CLR_PER_CYC'(1) << (w_st_cell & c_lane_mask);
            w_ram_wdata = bus.st_data;
        end
    end

    tape_ram #(
        .DEPTH   (DEPTH),
        .LANES   (CLR_PER_CYC)
    ) u_tape_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_wbase (w_ram_wbase),
        .i_wmask (w_ram_wmask),
        .i_wdata (w_ram_wdata),
        .i_raddr (w_ld_cell),
        .o_rdata (w_ram_q)
    );

    // ------------------------------------------------------------------
    // Load pipeline.
    // Stage 1 (edge ending T): RAM captures the pre-store cell value and
    // a same-cycle store to the same cell is remembered for forwarding.
    // Stage 2 (edge ending T+1): the result is chosen and registered, so a
    // store in T+1 cannot leak into a load accepted in T.
    // ------------------------------------------------------------------
    logic [LD_LATENCY-1:0] r_vld_pipe;
    logic                  r_p1_fwd;
    logic [CELL_W-1:0]     r_p1_fwd_data;
    logic                  r_p1_oor;
    logic [CELL_W-1:0]     r_ld_data;
    logic [CELL_W-1:0]     w_ld_result;

    always_comb begin
        w_ld_result = '0;
        if (r_vld_pipe[0] && !r_p1_oor) begin
            w_ld_result = r_p1_fwd ? r_p1_fwd_data : w_ram_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vld_pipe    <= '0;
            r_p1_fwd      <= 1'b0;
            r_p1_fwd_data <= '0;
            r_p1_oor      <= 1'b0;
            r_ld_data     <= '0;
        end else begin
            r_vld_pipe    <= {r_vld_pipe[LD_LATENCY-2:0], w_ld_acc};
            r_p1_fwd      <= w_st_wr && (w_st_cell == w_ld_cell);
            r_p1_fwd_data <= bus.st_data;
            r_p1_oor      <= w_ld_oor;
            r_ld_data     <= w_ld_result;
        end
    end

    assign bus.ld_valid = r_vld_pipe[LD_LATENCY-1];
    assign bus.ld_data  = r_ld_data;
    assign bus.ready    = r_ready;

endmodule : tape_mem
`default_nettype wire

// File: tb/tb_tape_mem.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tape_mem
//  Description : Directed self-checking bench for tape_mem with DEPTH=16,
//                CLR_PER_CYC=1. Inputs change 1 ns after a rising edge and
//                outputs are checked at the same point.
//                Honours TAPE_MEM_RANGE_CHECK_EN for out-of-range checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_tape_mem;
    import tape_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    tape_mem_if bus ();

    tape_mem #(
        .DEPTH       (16),
        .CLR_PER_CYC (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] d);
        chk({tag, "_valid"}, {31'd0, bus.ld_valid}, {31'd0, v});
        chk({tag, "_data"},  {16'd0, bus.ld_data},  {16'd0, d});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic le, input logic [15:0] la,
                         input logic se, input logic [15:0] sa, input logic [15:0] sd);
        bus.ld_en   = le;
        bus.ld_addr = la;
        bus.st_en   = se;
        bus.st_addr = sa;
        bus.st_data = sd;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0, 1'b0, 16'h0, 16'h0);
    endtask

    // Called right after rst is released: ready must stay low for 16
    // cycles and rise on the 17th; requests during clear are ignored.
    task automatic wait_clear(input string tag, input bit junk);
        for (int k = 1; k <= 16; k++) begin
            if (junk) drive(1'b1, 16'h5, 1'b1, 16'h5, 16'hFFFF);
            else      idle();
            tick();
            if (k == 16) idle();
            chk({tag, "_ready"}, {31'd0, bus.ready}, {31'd0, (k == 16)});
            chk_out({tag, "_clr"}, 1'b0, 16'h0);
        end
        tick();
        chk_out({tag, "_post"}, 1'b0, 16'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        idle();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_ready", {31'd0, bus.ready}, 32'd0);
        chk("rst_err",   {31'd0, bus.err},   32'd0);
        chk_out("rst", 1'b0, 16'h0);

        // Power-up clear with junk requests that must be ignored
        rst = 1'b0;
        wait_clear("clr0", 1'b1);

        // Every cell reads back as zero, back-to-back loads
        for (int i = 0; i <= 17; i++) begin
            if (i < 16) drive(1'b1, 16'(i), 1'b0, 16'h0, 16'h0);
            else        idle();
            tick();
            chk_out($sformatf("zero%0d", i), (i >= 1 && i <= 16), 16'h0);
        end

        // Store 5 to cell 3, load cell 3 the next cycle
        drive(1'b0, 16'h0, 1'b1, 16'h3, 16'h0005);
        tick();
        drive(1'b1, 16'h3, 1'b0, 16'h0, 16'h0);
        tick();
        idle();
        chk_out("st_ld_gap", 1'b0, 16'h0);
        tick();
        chk_out("st_ld", 1'b1, 16'h0005);
        tick();
        chk_out("st_ld_after", 1'b0, 16'h0);

        // Same-cycle store and load to cell 7
        drive(1'b1, 16'h7, 1'b1, 16'h7, 16'hBEEF);
        tick();
        idle();
        tick();
        chk_out("fwd", 1'b1, 16'hBEEF);

        // Load cell 2 (=1), store 2 to cell 2 one cycle later
        drive(1'b0, 16'h0, 1'b1, 16'h2, 16'h0001);
        tick();
        drive(1'b1, 16'h2, 1'b0, 16'h0, 16'h0);
        tick();
        drive(1'b0, 16'h0, 1'b1, 16'h2, 16'h0002);
        tick();
        idle();
        chk_out("old_val", 1'b1, 16'h0001);
        tick();
        chk_out("old_val_after", 1'b0, 16'h0);

        // Pipelined loads to cells 1, 2, 3
        drive(1'b0, 16'h0, 1'b1, 16'h1, 16'h1111);
        tick();
        drive(1'b0, 16'h0, 1'b1, 16'h3, 16'h3333);
        tick();
        drive(1'b1, 16'h1, 1'b0, 16'h0, 16'h0);
        tick();
        drive(1'b1, 16'h2, 1'b0, 16'h0, 16'h0);
        tick();
        chk_out("pipe1", 1'b1, 16'h1111);
        drive(1'b1, 16'h3, 1'b0, 16'h0, 16'h0);
        tick();
        chk_out("pipe2", 1'b1, 16'h0002);
        idle();
        tick();
        chk_out("pipe3", 1'b1, 16'h3333);
        tick();
        chk_out("pipe_end", 1'b0, 16'h0);

        // Reset with a load in flight: no ld_valid, clear restarts
        drive(1'b1, 16'h1, 1'b0, 16'h0, 16'h0);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("rst_fl_ready", {31'd0, bus.ready}, 32'd0);
        chk_out("rst_fl", 1'b0, 16'h0);
        tick();
        rst = 1'b0;
        wait_clear("clr1", 1'b0);

        // Cell 1 was zeroed by the new clear
        drive(1'b1, 16'h1, 1'b0, 16'h0, 16'h0);
        tick();
        idle();
        tick();
        chk_out("recleared", 1'b1, 16'h0);

        // Reset in the middle of a clear restarts the full sequence
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        chk("mid_clr_ready", {31'd0, bus.ready}, 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        wait_clear("clr2", 1'b0);

        // Out-of-range addresses
        drive(1'b0, 16'h0, 1'b1, 16'h1, 16'hA5A5);
        tick();
        drive(1'b1, 16'h0011, 1'b0, 16'h0, 16'h0);
        tick();
        idle();
        tick();
`ifdef TAPE_MEM_RANGE_CHECK_EN
        chk_out("oor_ld", 1'b1, 16'h0);
        chk("oor_err", {31'd0, bus.err}, 32'd1);
`else
        chk_out("wrap_ld", 1'b1, 16'hA5A5);
        chk("wrap_err", {31'd0, bus.err}, 32'd0);
`endif
        drive(1'b0, 16'h0, 1'b1, 16'h0013, 16'h7777);
        tick();
        drive(1'b1, 16'h3, 1'b0, 16'h0, 16'h0);
        tick();
        idle();
        tick();
`ifdef TAPE_MEM_RANGE_CHECK_EN
        chk_out("oor_st", 1'b1, 16'h0);
`else
        chk_out("wrap_st", 1'b1, 16'h7777);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_tape_mem
`default_nettype wire
